// File: rtl/uart_bus_master_if.sv
// Wishbone-style single-cycle bus between the UART command decoder and the krake core.
interface uart_bus_master_if;
    logic       stb_o;
    logic       we_o;
    logic [7:0] adr_o;
    logic [7:0] dat_o;
    logic       ack_i;

    modport master (output stb_o, we_o, adr_o, dat_o, input ack_i);
    modport slave  (input stb_o, we_o, adr_o, dat_o, output ack_i);
endinterface

// File: rtl/uart_bus_master.sv
// UART 8N1 command receiver: 'W' adr dat -> write cycle, 'R' adr -> read cycle on the
// internal bus, with frame, command and acknowledge-timeout error pulses.
module uart_bus_master #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned ACK_TIMEOUT  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rxd,
    uart_bus_master_if.master bus,
    output logic              busy,
    output logic              frame_err,
    output logic              cmd_err,
    output logic              to_err
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {P_CMD, P_ADR, P_DAT, P_BUS} p_state_t;

    logic          rxd_m, rxd_s, rxd_d;
    rx_state_t     rx_state;
    logic [CW-1:0] bit_tmr;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift, hold;
    logic          byte_vld;
    p_state_t      p_state;
    logic          we_r;
    logic [TW-1:0] to_cnt;
    logic          half_c, full_c, stop_ok_c, stop_bad_c, take_c;

    assign half_c     = (bit_tmr == CW'(CLKS_PER_BIT / 2 - 1));
    assign full_c     = (bit_tmr == CW'(CLKS_PER_BIT - 1));
    assign stop_ok_c  = (rx_state == R_STOP) && full_c && rxd_s;
    assign stop_bad_c = (rx_state == R_STOP) && full_c && !rxd_s;
    // A frame error pre-empts consumption so the held byte survives for the next cycle
    assign take_c     = byte_vld && (p_state != P_BUS) && !stop_bad_c;
    assign busy       = (p_state != P_CMD) | byte_vld;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    // Receiver: mid-bit sampling, never stalls, single-entry holding register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_state  <= R_IDLE;
            bit_tmr   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            hold      <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad_c;
            if (stop_ok_c) begin
                hold     <= shift;
                byte_vld <= 1'b1;
            end else if (take_c) begin
                byte_vld <= 1'b0;
            end
            case (rx_state)
                R_IDLE: begin
                    bit_tmr <= '0;
                    bit_cnt <= '0;
                    if (rxd_d && !rxd_s) rx_state <= R_START;
                end
                R_START: begin
                    if (half_c) begin
                        bit_tmr  <= '0;
                        rx_state <= rxd_s ? R_IDLE : R_DATA;
                    end else begin
                        bit_tmr <= bit_tmr + CW'(1);
                    end
                end
                R_DATA: begin
                    if (full_c) begin
                        bit_tmr <= '0;
                        shift   <= {rxd_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) rx_state <= R_STOP;
                    end else begin
                        bit_tmr <= bit_tmr + CW'(1);
                    end
                end
                R_STOP: begin
                    if (full_c) begin
                        bit_tmr  <= '0;
                        rx_state <= R_IDLE;
                    end else begin
                        bit_tmr <= bit_tmr + CW'(1);
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Parser and bus cycle generator
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            p_state   <= P_CMD;
            we_r      <= 1'b0;
            to_cnt    <= '0;
            bus.stb_o <= 1'b0;
            bus.we_o  <= 1'b0;
            bus.adr_o <= '0;
            bus.dat_o <= '0;
            cmd_err   <= 1'b0;
            to_err    <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            to_err  <= 1'b0;
            if (stop_bad_c && (p_state != P_BUS)) begin
                p_state <= P_CMD;
            end else begin
                case (p_state)
                    P_CMD: begin
                        if (byte_vld) begin
                            if (hold == CMD_WR) begin
                                we_r    <= 1'b1;
                                p_state <= P_ADR;
                            end else if (hold == CMD_RD) begin
                                we_r    <= 1'b0;
                                p_state <= P_ADR;
                            end else begin
                                cmd_err <= 1'b1;
                            end
                        end
                    end
                    P_ADR: begin
                        if (byte_vld) begin
                            bus.adr_o <= hold;
                            if (we_r) begin
                                p_state <= P_DAT;
                            end else begin
                                bus.stb_o <= 1'b1;
                                bus.we_o  <= 1'b0;
                                to_cnt    <= '0;
                                p_state   <= P_BUS;
                            end
                        end
                    end
                    P_DAT: begin
                        if (byte_vld) begin
                            bus.dat_o <= hold;
                            bus.stb_o <= 1'b1;
                            bus.we_o  <= 1'b1;
                            to_cnt    <= '0;
                            p_state   <= P_BUS;
                        end
                    end
                    P_BUS: begin
                        if (bus.ack_i) begin
                            bus.stb_o <= 1'b0;
                            bus.we_o  <= 1'b0;
                            p_state   <= P_CMD;
                        end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                            bus.stb_o <= 1'b0;
                            bus.we_o  <= 1'b0;
                            to_err    <= 1'b1;
                            p_state   <= P_CMD;
                        end else begin
                            to_cnt <= to_cnt + TW'(1);
                        end
                    end
                    default: p_state <= P_CMD;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench: serial frames in, expected bus cycles queued, monitor checks each cycle.
module tb_uart_bus_master;
    localparam int CPB = 16;
    localparam int TO  = 8;

    typedef struct {
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
        int         len;
        logic       to;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic rxd   = 1'b1;
    logic busy, frame_err, cmd_err, to_err;
    uart_bus_master_if bus_if ();

    uart_bus_master #(.CLKS_PER_BIT(CPB), .ACK_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rxd(rxd), .bus(bus_if),
        .busy(busy), .frame_err(frame_err), .cmd_err(cmd_err), .to_err(to_err)
    );

    always #5 clk_i = ~clk_i;

    int   n_checks = 0, n_pass = 0;
    int   ack_delay = 0, hi_cnt = 0;
    int   fe_exp = 0, ce_exp = 0, te_exp = 0;
    int   fe_seen = 0, ce_seen = 0, te_seen = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Slave: acks once stb has been high for more than ack_delay cycles; random noise otherwise
    always @(posedge clk_i) begin
        #1;
        if (bus_if.stb_o) begin
            hi_cnt++;
            bus_if.ack_i = (hi_cnt > ack_delay);
        end else begin
            hi_cnt = 0;
            bus_if.ack_i = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: pops an expected cycle on each stb rise and checks it on the fall
    logic in_cyc = 1'b0, have = 1'b0, stable = 1'b1;
    int   hi = 0;
    exp_t cur;
    always @(negedge clk_i) begin
        if (bus_if.stb_o && !in_cyc) begin
            in_cyc = 1'b1;
            hi = 1;
            stable = 1'b1;
            check("stb_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                have = 1'b1;
                check("cyc_adr", 32'(bus_if.adr_o), 32'(cur.adr));
                check("cyc_we", 32'(bus_if.we_o), 32'(cur.we));
                if (cur.we) check("cyc_dat", 32'(bus_if.dat_o), 32'(cur.dat));
                check("cyc_busy", 32'(busy), 1);
            end
        end else if (bus_if.stb_o) begin
            hi++;
            if (have && (bus_if.adr_o !== cur.adr || bus_if.we_o !== cur.we ||
                         (cur.we && bus_if.dat_o !== cur.dat))) stable = 1'b0;
        end else if (in_cyc) begin
            in_cyc = 1'b0;
            if (rst_i && have) begin
                check("cyc_len", 32'(hi), 32'(cur.len));
                check("cyc_to_err", 32'(to_err), 32'(cur.to));
                check("cyc_stable", 32'(stable), 1);
            end
            have = 1'b0;
        end
        if (frame_err) fe_seen++;
        if (cmd_err)   ce_seen++;
        if (to_err)    te_seen++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i) rxd = bits[i];
            repeat (CPB - 1) @(negedge clk_i);
        end
        @(negedge clk_i) rxd = 1'b1;
        repeat ($urandom_range(2, 6)) @(negedge clk_i);
    endtask

    task automatic push_cycle(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                              input int d);
        exp_t e;
        e.we = we; e.adr = adr; e.dat = dat;
        e.to  = (d >= TO);
        e.len = (d >= TO) ? TO : d + 1;
        if (e.to) te_exp++;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                              input int d);
        ack_delay = d;
        push_cycle(we, adr, dat, d);
        send_byte(we ? 8'h57 : 8'h52);
        send_byte(adr);
        if (we) send_byte(dat);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && (busy || bus_if.stb_o); i++) @(negedge clk_i);
        repeat (4) @(negedge clk_i);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_stb"}, 32'(bus_if.stb_o), 0);
        check({tag, "_errs"}, {8'(fe_seen), 8'(ce_seen), 8'(te_seen)},
                              {8'(fe_exp), 8'(ce_exp), 8'(te_exp)});
    endtask

    initial begin
        repeat (80000) @(posedge clk_i);
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int kind;
        bus_if.ack_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_outs", {bus_if.stb_o, bus_if.we_o, busy, frame_err, cmd_err, to_err},
                          6'b0);
        check("rst_adr_dat", {bus_if.adr_o, bus_if.dat_o}, 16'h0);
        rst_i = 1'b1;
        repeat (5) @(negedge clk_i);

        send_frame(1'b1, 8'h35, 8'hA5, 1);
        wait_idle("wr_ack1");
        send_frame(1'b0, 8'h40, 8'h00, 3);
        wait_idle("rd_ack3");
        send_frame(1'b1, 8'h10, 8'h01, 1000);
        wait_idle("wr_timeout");
        send_frame(1'b0, 8'h10, 8'h00, 2);
        wait_idle("rd_recover");
        send_frame(1'b1, 8'h7E, 8'hC3, TO - 1);
        wait_idle("wr_ack_last");

        ce_exp++;
        send_byte(8'h33);
        send_frame(1'b0, 8'h20, 8'h00, 0);
        wait_idle("bad_cmd");

        fe_exp++;
        send_byte(8'h57, 1'b0);
        send_frame(1'b0, 8'h00, 8'h00, 1);
        wait_idle("frame_err");

        @(negedge clk_i) rxd = 1'b0;
        repeat (4) @(negedge clk_i);
        rxd = 1'b1;
        repeat (60) @(negedge clk_i);
        wait_idle("glitch");

        // Reset while the bus cycle is pending: stb must drop without any error pulse
        ack_delay = 1000;
        push_cycle(1'b0, 8'h11, 8'h00, 0);
        fork
            begin send_byte(8'h52); send_byte(8'h11); end
        join_none
        for (int i = 0; i < 400 && !bus_if.stb_o; i++) @(negedge clk_i);
        check("rst_stb_seen", 32'(bus_if.stb_o), 1);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_abort", {bus_if.stb_o, bus_if.we_o, busy, to_err}, 4'b0);
        wait fork;
        @(negedge clk_i) rst_i = 1'b1;
        repeat (4) @(negedge clk_i);
        send_frame(1'b0, 8'h11, 8'h00, 2);
        wait_idle("after_rst");

        for (int n = 0; n < 20; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
                ce_exp++;
                send_byte(b);
            end else if (kind == 1) begin
                fe_exp++;
                if ($urandom_range(0, 1) == 1) begin
                    send_byte(8'h57);
                    send_byte(8'($urandom));
                end else begin
                    send_byte(8'h52);
                end
                send_byte(8'($urandom), 1'b0);
            end else begin
                send_frame(1'($urandom), 8'($urandom), 8'($urandom),
                           int'($urandom_range(0, TO + 2)));
            end
            wait_idle("rand");
        end

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
